// File: rtl/st_pair_integrator_pkg.sv
// Shared types and the saturation helper for the pairing integrator.
// sat_n works on a wide fixed container so one function serves every width N <= MAX_N.
package st_pair_integrator_pkg;

   localparam int MAX_N = 64;

   typedef enum logic [1:0] {
      MODE_SUM   = 2'b00,
      MODE_DIFF  = 2'b01,
      MODE_ISUM  = 2'b10,
      MODE_IDIFF = 2'b11
   } mode_e;

   typedef struct packed {
      logic signed [MAX_N-1:0] value;
      logic                    ovf;
   } sat_res_t;

   localparam logic signed [MAX_N+1:0] ONE_W = 1;

   // r must already be sign-extended from N+2 bits; caller keeps value[n-1:0].
   function automatic sat_res_t sat_n(input logic signed [MAX_N+1:0] r,
                                      input int n,
                                      input logic sat_en);
      sat_res_t res;
      logic signed [MAX_N+1:0] hi;
      logic signed [MAX_N+1:0] lo;
      hi = (ONE_W <<< (n - 1)) - ONE_W;
      lo = -hi - ONE_W;
      res.ovf = (r > hi) || (r < lo);
      if (res.ovf && sat_en)
         res.value = (r > hi) ? hi[MAX_N-1:0] : lo[MAX_N-1:0];
      else
         res.value = r[MAX_N-1:0];
      return res;
   endfunction

endpackage

// File: rtl/st_pair_integrator_if.sv
// Avalon-ST bundle for the pairing integrator: two operand sinks and one result source.
// Handshake: a beat transfers on a rising edge where valid && ready; a source holds data/valid until then.
interface st_pair_integrator_if #(parameter int N = 32);
   logic [N-1:0] asi_in0_data;
   logic         asi_in0_valid;
   logic         asi_in0_ready;
   logic [N-1:0] asi_in1_data;
   logic         asi_in1_valid;
   logic         asi_in1_ready;
   logic [N-1:0] aso_out0_data;
   logic         aso_out0_valid;
   logic         aso_out0_ready;

   modport slave (
      input  asi_in0_data, asi_in0_valid, output asi_in0_ready,
      input  asi_in1_data, asi_in1_valid, output asi_in1_ready,
      output aso_out0_data, aso_out0_valid, input aso_out0_ready
   );

   modport master (
      output asi_in0_data, asi_in0_valid, input asi_in0_ready,
      output asi_in1_data, asi_in1_valid, input asi_in1_ready,
      input  aso_out0_data, aso_out0_valid, output aso_out0_ready
   );
endinterface

// File: rtl/st_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered full flag.
// Callers must only push when !full and only pop when !empty.
module st_sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [AW:0]  wr_next;
   logic [AW:0]  rd_next;

   always_comb begin
      wr_next = wr_ptr + (AW+1)'(push);
      rd_next = rd_ptr + (AW+1)'(pop);
   end

   // full resets high so the upstream sees ready=0 until the first edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b1;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         full   <= (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign pop_data = mem[rd_ptr[AW-1:0]];
   assign empty    = (wr_ptr == rd_ptr);

endmodule

// File: rtl/st_pair_integrator.sv
// Pairs operand streams A and B in order and emits sum, difference or a running integral,
// saturated or wrapped to N bits, through a single backpressured output register.
module st_pair_integrator
   import st_pair_integrator_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 4,
   parameter bit SAT   = 1'b1
) (
   input  logic               clock_clk,
   input  logic               reset_reset,
   st_pair_integrator_if.slave st,
   input  logic [1:0]         cfg_mode,
   input  logic               cfg_clear,
   output logic               sts_overflow
);
   logic         full0, empty0, full1, empty1;
   logic         push0, push1, pop_pair;
   logic [N-1:0] a_data, b_data;

   mode_e                mode;
   logic                 integ;
   logic signed [N-1:0]  acc;
   logic signed [N+1:0]  a_ext, b_ext, t, acc_ext, r;
   sat_res_t             sat_res;
   logic [N-1:0]         res_n;
   logic                 unused_sat_bits;

   logic [N-1:0]         out_data;
   logic                 out_valid;

   assign push0    = st.asi_in0_valid && !full0;
   assign push1    = st.asi_in1_valid && !full1;
   assign pop_pair = !empty0 && !empty1 && (!out_valid || st.aso_out0_ready);

   assign st.asi_in0_ready  = !full0;
   assign st.asi_in1_ready  = !full1;
   assign st.aso_out0_data  = out_data;
   assign st.aso_out0_valid = out_valid;

   st_sync_fifo #(.W(N), .DEPTH(DEPTH)) u_fifo_a (
      .clk(clock_clk), .rst(reset_reset),
      .push(push0), .push_data(st.asi_in0_data),
      .pop(pop_pair), .pop_data(a_data),
      .full(full0), .empty(empty0)
   );

   st_sync_fifo #(.W(N), .DEPTH(DEPTH)) u_fifo_b (
      .clk(clock_clk), .rst(reset_reset),
      .push(push1), .push_data(st.asi_in1_data),
      .pop(pop_pair), .pop_data(b_data),
      .full(full1), .empty(empty1)
   );

   // N+2 bits hold acc + (A +/- B) without loss; a same-cycle clear makes the pop see acc=0.
   always_comb begin
      mode    = mode_e'(cfg_mode);
      integ   = (mode == MODE_ISUM) || (mode == MODE_IDIFF);
      a_ext   = (N+2)'($signed(a_data));
      b_ext   = (N+2)'($signed(b_data));
      t       = ((mode == MODE_DIFF) || (mode == MODE_IDIFF)) ? (a_ext - b_ext) : (a_ext + b_ext);
      acc_ext = cfg_clear ? '0 : (N+2)'(acc);
      r       = integ ? (acc_ext + t) : t;
      sat_res = sat_n((MAX_N+2)'(r), N, SAT);
      res_n   = sat_res.value[N-1:0];
   end

   assign unused_sat_bits = ^sat_res.value;

   always_ff @(posedge clock_clk or posedge reset_reset) begin
      if (reset_reset) begin
         out_data     <= '0;
         out_valid    <= 1'b0;
         acc          <= '0;
         sts_overflow <= 1'b0;
      end else begin
         if (pop_pair) begin
            out_data  <= res_n;
            out_valid <= 1'b1;
         end else if (st.aso_out0_ready) begin
            out_valid <= 1'b0;
         end

         if (pop_pair && integ)
            acc <= res_n;
         else if (cfg_clear)
            acc <= '0;

         // An overflow on the same edge as a clear wins.
         if (pop_pair && sat_res.ovf)
            sts_overflow <= 1'b1;
         else if (cfg_clear)
            sts_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_st_pair_integrator.sv
// Directed bench for st_pair_integrator: a queue-based pairing/arithmetic model checks every
// accepted result, and literal expectations pin the model on the documented scenarios.
module tb_st_pair_integrator;
   import st_pair_integrator_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   st_pair_integrator_if #(32) bus ();
   st_pair_integrator_if #(8)  i8s ();
   st_pair_integrator_if #(8)  i8w ();

   logic [1:0] cfg_mode  = 2'b00;
   logic [1:0] cfg8_mode = 2'b00;
   logic       cfg_clear = 1'b0;
   logic       clear8    = 1'b0;
   logic       sts, sts8s, sts8w;

   st_pair_integrator #(.N(32), .DEPTH(4), .SAT(1'b1)) dut (
      .clock_clk(clk), .reset_reset(rst), .st(bus),
      .cfg_mode(cfg_mode), .cfg_clear(cfg_clear), .sts_overflow(sts)
   );
   st_pair_integrator #(.N(8), .DEPTH(4), .SAT(1'b1)) dut8s (
      .clock_clk(clk), .reset_reset(rst), .st(i8s),
      .cfg_mode(cfg8_mode), .cfg_clear(clear8), .sts_overflow(sts8s)
   );
   st_pair_integrator #(.N(8), .DEPTH(4), .SAT(1'b0)) dut8w (
      .clock_clk(clk), .reset_reset(rst), .st(i8w),
      .cfg_mode(cfg8_mode), .cfg_clear(clear8), .sts_overflow(sts8w)
   );

   assign i8w.asi_in0_data  = i8s.asi_in0_data;
   assign i8w.asi_in0_valid = i8s.asi_in0_valid;
   assign i8w.asi_in1_data  = i8s.asi_in1_data;
   assign i8w.asi_in1_valid = i8s.asi_in1_valid;
   assign i8w.aso_out0_ready = i8s.aso_out0_ready;

   int n_checks = 0;
   int n_errors = 0;

   longint      qa[$];
   longint      qb[$];
   logic [31:0] exp_q[$];
   logic [31:0] out_log[$];
   longint      m_acc = 0;
   bit          m_ovf = 1'b0;
   bit          stall_prev = 1'b0;
   logic [31:0] stall_data = '0;
   bit          a_done, b_done;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired or item missing", name);
   endtask

   task automatic log_at(input int i, input string name, input logic [31:0] exp);
      if (i < out_log.size()) check(name, out_log[i], exp);
      else fail_now(name);
   endtask

   function automatic longint sat_model(input longint r, input int n, output bit ovf);
      longint hi, lo;
      hi  = (64'sd1 <<< (n - 1)) - 64'sd1;
      lo  = -hi - 64'sd1;
      ovf = (r > hi) || (r < lo);
      if (r > hi) return hi;
      if (r < lo) return lo;
      return r;
   endfunction

   // Operands pair strictly in arrival order; integrate modes carry a saturated accumulator.
   task automatic model_pair(input longint a, input longint b);
      longint t, r, res;
      bit o;
      t = cfg_mode[0] ? (a - b) : (a + b);
      r = cfg_mode[1] ? (m_acc + t) : t;
      res = sat_model(r, 32, o);
      if (o) m_ovf = 1'b1;
      if (cfg_mode[1]) m_acc = res;
      exp_q.push_back(res[31:0]);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         qa.delete(); qb.delete(); exp_q.delete(); out_log.delete();
         m_acc = 0; m_ovf = 1'b0; stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", 32'(bus.aso_out0_valid), 32'd1);
            check("hold_data", bus.aso_out0_data, stall_data);
         end
         if (bus.aso_out0_valid && bus.aso_out0_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_out: got %0h expected no result", bus.aso_out0_data);
            end else begin
               check("out_data", bus.aso_out0_data, exp_q.pop_front());
            end
            out_log.push_back(bus.aso_out0_data);
         end
         stall_prev = bus.aso_out0_valid && !bus.aso_out0_ready;
         stall_data = bus.aso_out0_data;
         if (cfg_clear) begin m_acc = 0; m_ovf = 1'b0; end
         while (qa.size() > 0 && qb.size() > 0) model_pair(qa.pop_front(), qb.pop_front());
         if (bus.asi_in0_valid && bus.asi_in0_ready) qa.push_back(longint'($signed(bus.asi_in0_data)));
         if (bus.asi_in1_valid && bus.asi_in1_ready) qb.push_back(longint'($signed(bus.asi_in1_data)));
      end
   end

   task automatic push_a(input logic [31:0] d);
      int n = 0;
      bus.asi_in0_data = d; bus.asi_in0_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!bus.asi_in0_ready && n < 100);
      if (!bus.asi_in0_ready) fail_now("push_a_timeout");
      @(posedge clk); #1; bus.asi_in0_valid = 1'b0;
   endtask

   task automatic push_b(input logic [31:0] d);
      int n = 0;
      bus.asi_in1_data = d; bus.asi_in1_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!bus.asi_in1_ready && n < 100);
      if (!bus.asi_in1_ready) fail_now("push_b_timeout");
      @(posedge clk); #1; bus.asi_in1_valid = 1'b0;
   endtask

   task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input bit clr_at_pop);
      int n = 0;
      bus.asi_in0_data = a; bus.asi_in1_data = b;
      bus.asi_in0_valid = 1'b1; bus.asi_in1_valid = 1'b1;
      do begin @(negedge clk); n++; end
      while (!(bus.asi_in0_ready && bus.asi_in1_ready) && n < 100);
      if (!(bus.asi_in0_ready && bus.asi_in1_ready)) fail_now("push_pair_timeout");
      @(posedge clk); #1;
      bus.asi_in0_valid = 1'b0; bus.asi_in1_valid = 1'b0;
      if (clr_at_pop) begin
         cfg_clear = 1'b1;
         @(posedge clk); #1; cfg_clear = 1'b0;
      end
   endtask

   task automatic do_clear();
      cfg_clear = 1'b1;
      @(posedge clk); #1; cfg_clear = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin @(negedge clk); #1; n++; end
      while (!(exp_q.size() == 0 && qa.size() == 0 && qb.size() == 0 && !bus.aso_out0_valid) && n < 300);
      if (n >= 300) fail_now(name);
      @(posedge clk); #1;
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] rs, output logic [7:0] rw);
      int n = 0;
      i8s.asi_in0_data = a; i8s.asi_in1_data = b;
      i8s.asi_in0_valid = 1'b1; i8s.asi_in1_valid = 1'b1;
      do begin @(negedge clk); n++; end
      while (!(i8s.asi_in0_ready && i8s.asi_in1_ready) && n < 20);
      @(posedge clk); #1;
      i8s.asi_in0_valid = 1'b0; i8s.asi_in1_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!i8s.aso_out0_valid && n < 10);
      if (!i8s.aso_out0_valid) fail_now("run8_timeout");
      rs = i8s.aso_out0_data;
      rw = i8w.aso_out0_data;
      @(posedge clk); #1;
   endtask

   task automatic clear8_pulse();
      clear8 = 1'b1;
      @(posedge clk); #1; clear8 = 1'b0;
   endtask

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      logic [7:0] rs, rw;
      bus.asi_in0_data = '0; bus.asi_in0_valid = 1'b0;
      bus.asi_in1_data = '0; bus.asi_in1_valid = 1'b0;
      bus.aso_out0_ready = 1'b1;
      i8s.asi_in0_data = '0; i8s.asi_in0_valid = 1'b0;
      i8s.asi_in1_data = '0; i8s.asi_in1_valid = 1'b0;
      i8s.aso_out0_ready = 1'b1;

      // Reset values, asynchronous and before any clock edge.
      #1 rst = 1'b1;
      #2;
      check("rst_ready0", 32'(bus.asi_in0_ready), 32'd0);
      check("rst_ready1", 32'(bus.asi_in1_ready), 32'd0);
      check("rst_valid", 32'(bus.aso_out0_valid), 32'd0);
      check("rst_data", bus.aso_out0_data, 32'd0);
      check("rst_sts", 32'(sts), 32'd0);
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check("ready_pre_edge", 32'(bus.asi_in0_ready), 32'd0);
      @(negedge clk);
      check("ready0_post_edge", 32'(bus.asi_in0_ready), 32'd1);
      check("ready1_post_edge", 32'(bus.asi_in1_ready), 32'd1);

      // Test 1: 5+7, result valid two cycles after the handshake for one cycle.
      @(posedge clk); #1;
      cfg_mode = MODE_SUM;
      push_pair(32'd5, 32'd7, 1'b0);
      @(negedge clk);
      check("t1_lat_valid1", 32'(bus.aso_out0_valid), 32'd0);
      @(negedge clk);
      check("t1_lat_valid2", 32'(bus.aso_out0_valid), 32'd1);
      check("t1_data", bus.aso_out0_data, 32'd12);
      @(negedge clk);
      check("t1_valid_drop", 32'(bus.aso_out0_valid), 32'd0);
      wait_idle("t1_idle");

      // Test 2: running sum, clear, then a fresh integral.
      out_log.delete();
      cfg_mode = MODE_ISUM;
      push_pair(32'd1, 32'd2, 1'b0);
      push_pair(32'd3, 32'd4, 1'b0);
      push_pair(32'd5, 32'd6, 1'b0);
      wait_idle("t2_idle");
      log_at(0, "t2_r0", 32'd3);
      log_at(1, "t2_r1", 32'd10);
      log_at(2, "t2_r2", 32'd21);
      do_clear();
      push_pair(32'd1, 32'd1, 1'b0);
      wait_idle("t2b_idle");
      log_at(3, "t2_after_clear", 32'd2);
      check("t2_sts", 32'(sts), 32'd0);

      // Clear coincident with an integrate pop: acc=2 is ignored, R=9, acc continues from 9.
      push_pair(32'd4, 32'd5, 1'b1);
      push_pair(32'd1, 32'd0, 1'b0);
      wait_idle("tc_idle");
      log_at(4, "tc_clear_pop", 32'd9);
      log_at(5, "tc_next", 32'd10);

      // 32-bit saturation at both ends.
      cfg_mode = MODE_SUM;
      push_pair(32'h7fff_ffff, 32'd1, 1'b0);
      push_pair(32'h8000_0000, 32'hffff_ffff, 1'b0);
      wait_idle("tsat_idle");
      log_at(6, "tsat_hi", 32'h7fff_ffff);
      log_at(7, "tsat_lo", 32'h8000_0000);
      check("tsat_sts", 32'(sts), 32'd1);
      check("tsat_sts_model", 32'(sts), 32'(m_ovf));
      do_clear();
      @(negedge clk);
      check("tsat_sts_cleared", 32'(sts), 32'd0);

      // Test 3: 8-bit saturate vs wrap.
      cfg8_mode = MODE_SUM;
      run8(8'd100, 8'd100, rs, rw);
      check("t3_sat_sum", 32'(rs), 32'h7f);
      check("t3_wrap_sum", 32'(rw), 32'hc8);
      check("t3_sat_sts", 32'(sts8s), 32'd1);
      check("t3_wrap_sts", 32'(sts8w), 32'd1);
      clear8_pulse();
      check("t3_sts_clr", 32'({sts8s, sts8w}), 32'd0);
      cfg8_mode = MODE_DIFF;
      run8(8'h9c, 8'd100, rs, rw);
      check("t3_sat_diff", 32'(rs), 32'h80);
      check("t3_wrap_diff", 32'(rw), 32'h38);
      clear8_pulse();
      cfg8_mode = MODE_ISUM;
      run8(8'd60, 8'd60, rs, rw);
      check("t3_int0_sat", 32'(rs), 32'h78);
      check("t3_int0_wrap", 32'(rw), 32'h78);
      check("t3_int0_sts", 32'({sts8s, sts8w}), 32'd0);
      run8(8'd5, 8'd5, rs, rw);
      check("t3_int1_sat", 32'(rs), 32'h7f);
      check("t3_int1_wrap", 32'(rw), 32'h82);
      run8(8'd1, 8'd0, rs, rw);
      check("t3_int2_sat", 32'(rs), 32'h7f);
      check("t3_int2_wrap", 32'(rw), 32'h83);

      // Test 4: backpressure, A fills its FIFO alone, then B drains in order.
      out_log.delete();
      cfg_mode = MODE_SUM;
      bus.aso_out0_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_a(32'(10 + i));
      @(negedge clk);
      check("t4_ready0_full", 32'(bus.asi_in0_ready), 32'd0);
      check("t4_ready1", 32'(bus.asi_in1_ready), 32'd1);
      check("t4_no_out", 32'(bus.aso_out0_valid), 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) push_b(32'(100 + i));
      repeat (3) @(negedge clk);
      check("t4_stall_valid", 32'(bus.aso_out0_valid), 32'd1);
      check("t4_stall_data", bus.aso_out0_data, 32'd110);
      @(posedge clk); #1;
      bus.aso_out0_ready = 1'b1;
      wait_idle("t4_idle");
      check("t4_count", 32'(out_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) log_at(i, "t4_order", 32'(110 + 2 * i));

      // Test 5: A leads B by 3 cycles, random gaps on both inputs and on ready.
      out_log.delete();
      cfg_mode = MODE_DIFF;
      a_done = 1'b0; b_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               push_a(32'(3 * i));
            end
            a_done = 1'b1;
         end
         begin
            repeat (3) begin @(posedge clk); #1; end
            for (int i = 0; i < 8; i++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               push_b(32'(i));
            end
            b_done = 1'b1;
         end
         begin
            while (!(a_done && b_done)) begin
               @(posedge clk); #1;
               bus.aso_out0_ready = 1'($urandom_range(0, 1));
            end
            bus.aso_out0_ready = 1'b1;
         end
      join
      wait_idle("t5_idle");
      check("t5_count", 32'(out_log.size()), 32'd8);
      for (int i = 0; i < 8; i++) log_at(i, "t5_order", 32'(2 * i));

      // Test 6: reset with buffered pairs and a pending result.
      cfg_mode = MODE_SUM;
      bus.aso_out0_ready = 1'b0;
      push_pair(32'd1, 32'd1, 1'b0);
      push_pair(32'd2, 32'd2, 1'b0);
      push_pair(32'd3, 32'd3, 1'b0);
      @(negedge clk);
      check("t6_pending", 32'(bus.aso_out0_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_ready0", 32'(bus.asi_in0_ready), 32'd0);
      check("t6_rst_ready1", 32'(bus.asi_in1_ready), 32'd0);
      check("t6_rst_valid", 32'(bus.aso_out0_valid), 32'd0);
      check("t6_rst_data", bus.aso_out0_data, 32'd0);
      check("t6_rst_sts", 32'(sts), 32'd0);
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;
      bus.aso_out0_ready = 1'b1;
      @(posedge clk); #1;
      push_pair(32'd7, 32'd8, 1'b0);
      wait_idle("t6_idle");
      repeat (4) @(negedge clk);
      check("t6_count", 32'(out_log.size()), 32'd1);
      log_at(0, "t6_new_pair", 32'd15);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
